// File: rtl/ste_dma_snd_fifo_pkg.sv
// Shared definitions for the STE DMA-sound sample buffer.
//  - rate_e        : sample-rate encodings (RATE_6K..RATE_50K)
//  - MODE_BIT_*    : mode bit positions matching the STE $FF8921 register
//  - unpack_e      : unpacker modes built from {mode_16, mode_stereo}
//  - byte_phase_e  : which byte of the head word 8-bit mono plays next
//  - div_period()  : clk32 cycles per sample for a given rate
//  - unpack_mode() : maps the two mode pins onto unpack_e
//  - ste_mode_reg(): builds a $FF8921-style register image
package ste_dma_snd_fifo_pkg;

  typedef enum logic [1:0] {
    RATE_6K  = 2'd0,
    RATE_12K = 2'd1,
    RATE_25K = 2'd2,
    RATE_50K = 2'd3
  } rate_e;

  // $FF8921: bit 7 = mono, bit 6 = 16-bit, bits 1:0 = rate
  localparam int unsigned MODE_BIT_MONO = 7;
  localparam int unsigned MODE_BIT_16   = 6;
  localparam int unsigned RATE_LSB      = 0;

  typedef enum logic [1:0] {
    UNP_MONO8    = 2'b00,
    UNP_STEREO8  = 2'b01,
    UNP_MONO16   = 2'b10,
    UNP_STEREO16 = 2'b11
  } unpack_e;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } byte_phase_e;

  function automatic int unsigned div_period(input int unsigned base, input logic [1:0] rate);
    return base << (2'd3 - rate);
  endfunction

  function automatic unpack_e unpack_mode(input logic m16, input logic stereo);
    return unpack_e'({m16, stereo});
  endfunction

  function automatic logic [7:0] ste_mode_reg(input logic stereo, input logic m16, input rate_e r);
    logic [7:0] v;
    v = '0;
    v[MODE_BIT_MONO]  = !stereo;
    v[MODE_BIT_16]    = m16;
    v[RATE_LSB +: 2]  = r;
    return v;
  endfunction

endpackage

// File: rtl/ste_snd_fifo_mem.sv
// DEPTH x 16 dual-pointer FIFO for the DMA-sound path.
// Ports:
//  i_clk, i_rst_n         clock, asynchronous active-low reset
//  i_flush                synchronous clear (priority over push/pop)
//  i_push, i_wr_data      write one word
//  i_pop / i_pop2         remove one / two words (caller guarantees availability)
//  o_rd_data0/1           head word and the word behind it
//  o_level, o_level_next  current word count and the count after this cycle
//  o_full, o_empty        status flags
module ste_snd_fifo_mem #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_pop2,
  input  logic [15:0]              i_wr_data,
  output logic [15:0]              o_rd_data0,
  output logic [15:0]              o_rd_data1,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [$clog2(DEPTH):0]   o_level_next,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_pop_n;
  logic          w_do_push;

  always_comb begin
    w_pop_n = '0;
    if (i_pop2) begin
      w_pop_n = (AW+1)'(2);
    end else if (i_pop) begin
      w_pop_n = (AW+1)'(1);
    end
    // a push into a full FIFO is only accepted when a pop frees a slot in the same cycle
    w_do_push    = i_push && !i_flush && (!o_full || (w_pop_n != '0));
    o_level_next = i_flush ? '0 : (r_count + (AW+1)'(w_do_push) - w_pop_n);
  end

  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_level    = r_count;
  assign o_rd_data0 = r_mem[r_rd_ptr];
  assign o_rd_data1 = r_mem[r_rd_ptr + AW'(1)];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= r_rd_ptr + w_pop_n[AW-1:0];
      r_count  <= o_level_next;
    end
  end

endmodule

// File: rtl/ste_dma_snd_fifo.sv
// DMA-sound sample buffer and unpacker between the MCU sound-DMA handshake
// (SREQ / SLOAD_N, data on MDIN) and the audio DAC path.
// Ports:
//  clk32, resb              32 MHz clock, asynchronous active-low reset
//  enable                   playback on; 0 stops ticks and SREQ, keeps FIFO content
//  flush                    synchronous clear of FIFO, byte phase, divider, outputs
//  mode_stereo, mode_16     sample format; rate selects 6.25/12.5/25/50 kHz
//  MDIN, SLOAD_N            DMA data word, captured on the SLOAD_N rising edge
//  SREQ                     word request to the MCU
//  audio_left/right         signed samples, updated with the sample_tick pulse
//  level                    FIFO word count
//  overrun, underrun        sticky status, cleared by clr_status
module ste_dma_snd_fifo
  import ste_dma_snd_fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned REQ_FREE = 2,
  parameter int unsigned DIV_BASE = 640
) (
  input  logic                   clk32,
  input  logic                   resb,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   mode_stereo,
  input  logic                   mode_16,
  input  logic [1:0]             rate,
  input  logic [15:0]            MDIN,
  input  logic                   SLOAD_N,
  output logic                   SREQ,
  output logic [15:0]            audio_left,
  output logic [15:0]            audio_right,
  output logic                   sample_tick,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  output logic                   underrun,
  input  logic                   clr_status
);

  localparam int unsigned LW    = $clog2(DEPTH) + 1;
  localparam int unsigned DIV_W = $clog2(DIV_BASE << 3);

  logic             r_sload_q;
  logic             w_push;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_last;
  rate_e            r_rate_q;
  logic             w_tick;

  unpack_e          w_mode;
  unpack_e          r_mode_q;
  logic             w_mode_chg;
  byte_phase_e      r_phase;
  byte_phase_e      w_phase_cur;
  byte_phase_e      w_phase_next;

  logic [15:0]      w_rd0;
  logic [15:0]      w_rd1;
  logic [LW-1:0]    w_level;
  logic [LW-1:0]    w_level_next;
  logic             w_full;
  logic             w_empty;

  logic             w_have;
  logic             w_load;
  logic             w_pop;
  logic             w_pop2;
  logic [7:0]       w_byte;
  logic [15:0]      w_left_next;
  logic [15:0]      w_right_next;
  logic             w_overrun_evt;

  logic [15:0]      r_left;
  logic [15:0]      r_right;
  logic             r_tick;
  logic             r_sreq;
  logic             r_ovr;
  logic             r_unr;

  assign w_push = !r_sload_q && SLOAD_N;

  // The active rate is latched only when the divider wraps (or is held),
  // so a rate write never truncates or stretches the period in progress.
  assign w_div_last = DIV_W'(div_period(DIV_BASE, r_rate_q) - 1);
  assign w_tick     = enable && !flush && (r_div == w_div_last);

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_div    <= '0;
      r_rate_q <= RATE_50K;
    end else if (!enable || flush || w_tick) begin
      r_div    <= '0;
      r_rate_q <= rate_e'(rate);
    end else begin
      r_div    <= r_div + DIV_W'(1);
    end
  end

  ste_snd_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .i_clk        (clk32),
    .i_rst_n      (resb),
    .i_flush      (flush),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_pop2       (w_pop2),
    .i_wr_data    (MDIN),
    .o_rd_data0   (w_rd0),
    .o_rd_data1   (w_rd1),
    .o_level      (w_level),
    .o_level_next (w_level_next),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  assign w_mode     = unpack_mode(mode_16, mode_stereo);
  assign w_mode_chg = (w_mode != r_mode_q);

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_mode_q <= UNP_MONO8;
      r_phase  <= PH_HI;
    end else begin
      r_mode_q <= w_mode;
      r_phase  <= w_phase_next;
    end
  end

  // Unpacker: decides what the tick loads and how many words it consumes.
  // A mode change seen in the tick cycle itself already restarts at the high byte.
  always_comb begin
    w_phase_cur  = w_mode_chg ? PH_HI : r_phase;
    w_phase_next = w_phase_cur;
    w_pop        = 1'b0;
    w_pop2       = 1'b0;
    w_left_next  = r_left;
    w_right_next = r_right;
    w_byte       = (w_phase_cur == PH_HI) ? w_rd0[15:8] : w_rd0[7:0];
    w_have       = (w_mode == UNP_STEREO16) ? (w_level >= LW'(2)) : !w_empty;
    w_load       = w_tick && w_have;
    if (w_load) begin
      case (w_mode)
        UNP_MONO8: begin
          w_left_next  = {w_byte, 8'h00};
          w_right_next = {w_byte, 8'h00};
          w_pop        = (w_phase_cur == PH_LO);
          w_phase_next = (w_phase_cur == PH_HI) ? PH_LO : PH_HI;
        end
        UNP_STEREO8: begin
          w_left_next  = {w_rd0[15:8], 8'h00};
          w_right_next = {w_rd0[7:0], 8'h00};
          w_pop        = 1'b1;
        end
        UNP_MONO16: begin
          w_left_next  = w_rd0;
          w_right_next = w_rd0;
          w_pop        = 1'b1;
        end
        UNP_STEREO16: begin
          w_left_next  = w_rd0;
          w_right_next = w_rd1;
          w_pop2       = 1'b1;
        end
      endcase
    end
    if (flush) begin
      w_phase_next = PH_HI;
    end
  end

  assign w_overrun_evt = w_push && !flush && w_full && !(w_pop || w_pop2);

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_sload_q <= 1'b1;
      r_tick    <= 1'b0;
      r_left    <= '0;
      r_right   <= '0;
      r_sreq    <= 1'b0;
      r_ovr     <= 1'b0;
      r_unr     <= 1'b0;
    end else begin
      r_sload_q <= SLOAD_N;
      r_tick    <= w_tick;
      if (flush) begin
        r_left  <= '0;
        r_right <= '0;
      end else if (w_load) begin
        r_left  <= w_left_next;
        r_right <= w_right_next;
      end
      r_sreq <= enable && !flush && ((LW'(DEPTH) - w_level_next) >= LW'(REQ_FREE));
      if (clr_status) begin
        r_ovr <= 1'b0;
        r_unr <= 1'b0;
      end else begin
        if (w_overrun_evt) begin
          r_ovr <= 1'b1;
        end
        if (w_tick && !w_have) begin
          r_unr <= 1'b1;
        end
      end
    end
  end

  assign SREQ        = r_sreq;
  assign audio_left  = r_left;
  assign audio_right = r_right;
  assign sample_tick = r_tick;
  assign level       = w_level;
  assign overrun     = r_ovr;
  assign underrun    = r_unr;

endmodule

// File: tb/tb_ste_dma_snd_fifo.sv
// Bench for ste_dma_snd_fifo: directed stimulus with literal expectations,
// plus a queue-based reference model compared on every clock.
module tb_ste_dma_snd_fifo;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned REQ_FREE = 2;
  localparam int unsigned DIV_BASE = 640;
  localparam int unsigned LW       = $clog2(DEPTH) + 1;

  logic          clk32 = 1'b0;
  logic          resb;
  logic          enable;
  logic          flush;
  logic          mode_stereo;
  logic          mode_16;
  logic [1:0]    rate;
  logic [15:0]   MDIN;
  logic          SLOAD_N;
  logic          SREQ;
  logic [15:0]   audio_left;
  logic [15:0]   audio_right;
  logic          sample_tick;
  logic [LW-1:0] level;
  logic          overrun;
  logic          underrun;
  logic          clr_status;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  ste_dma_snd_fifo #(
    .DEPTH   (DEPTH),
    .REQ_FREE(REQ_FREE),
    .DIV_BASE(DIV_BASE)
  ) dut (
    .clk32      (clk32),
    .resb       (resb),
    .enable     (enable),
    .flush      (flush),
    .mode_stereo(mode_stereo),
    .mode_16    (mode_16),
    .rate       (rate),
    .MDIN       (MDIN),
    .SLOAD_N    (SLOAD_N),
    .SREQ       (SREQ),
    .audio_left (audio_left),
    .audio_right(audio_right),
    .sample_tick(sample_tick),
    .level      (level),
    .overrun    (overrun),
    .underrun   (underrun),
    .clr_status (clr_status)
  );

  always #5 clk32 = ~clk32;
  always @(posedge clk32) cyc++;

  // ---------------- reference model ----------------
  logic [15:0] q[$];
  bit          started = 0;
  bit          m_sload_q;
  int          m_cnt;
  int          m_period;
  bit          m_phase_hi;
  logic [1:0]  m_prev_mode;
  logic [15:0] m_l, m_r;
  bit          m_tick, m_ovr, m_unr, m_sreq;

  always @(posedge clk32 or negedge resb) begin : mdl
    bit          push, tick, unr_set, ovr_set;
    int          npop;
    int          need;
    logic [1:0]  mode;
    logic [15:0] w0, w1;
    logic [7:0]  b;
    started = 1;
    if (!resb) begin
      q.delete();
      m_sload_q = 1; m_cnt = 0; m_period = DIV_BASE; m_phase_hi = 1; m_prev_mode = 2'b00;
      m_l = '0; m_r = '0; m_tick = 0; m_ovr = 0; m_unr = 0; m_sreq = 0;
    end else begin
      push = !m_sload_q && SLOAD_N;
      m_sload_q = SLOAD_N;
      tick = 0; unr_set = 0; ovr_set = 0; npop = 0;
      mode = {mode_16, mode_stereo};
      if (!enable || flush) begin
        m_cnt = 0; m_period = DIV_BASE << (3 - int'(rate));
      end else if (m_cnt == m_period - 1) begin
        tick = 1; m_cnt = 0; m_period = DIV_BASE << (3 - int'(rate));
      end else begin
        m_cnt++;
      end
      if (mode != m_prev_mode) m_phase_hi = 1;
      m_prev_mode = mode;
      if (flush) begin
        q.delete();
        m_l = '0; m_r = '0; m_phase_hi = 1;
      end else begin
        if (tick) begin
          need = (mode == 2'b11) ? 2 : 1;
          if (q.size() >= need) begin
            w0 = q[0];
            w1 = (q.size() > 1) ? q[1] : 16'h0000;
            case (mode)
              2'b00: begin
                b = m_phase_hi ? w0[15:8] : w0[7:0];
                m_l = {b, 8'h00}; m_r = {b, 8'h00};
                if (!m_phase_hi) npop = 1;
                m_phase_hi = !m_phase_hi;
              end
              2'b01: begin m_l = {w0[15:8], 8'h00}; m_r = {w0[7:0], 8'h00}; npop = 1; end
              2'b10: begin m_l = w0; m_r = w0; npop = 1; end
              default: begin m_l = w0; m_r = w1; npop = 2; end
            endcase
          end else begin
            unr_set = 1;
          end
        end
        repeat (npop) void'(q.pop_front());
        if (push) begin
          if (q.size() < DEPTH) q.push_back(MDIN);
          else ovr_set = 1;
        end
      end
      if (clr_status) begin
        m_ovr = 0; m_unr = 0;
      end else begin
        if (ovr_set) m_ovr = 1;
        if (unr_set) m_unr = 1;
      end
      m_sreq = enable && !flush && ((int'(DEPTH) - q.size()) >= int'(REQ_FREE));
      m_tick = tick;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk32) begin
    if (started) begin
      checks++;
      if (SREQ !== m_sreq || int'(level) != q.size() || audio_left !== m_l || audio_right !== m_r ||
          sample_tick !== m_tick || overrun !== m_ovr || underrun !== m_unr) begin
        failures++;
        $display("FAIL model cycle %0d: SREQ=%b/%b level=%0d/%0d L=%h/%h R=%h/%h tick=%b/%b ovr=%b/%b unr=%b/%b (dut/model)",
                 cyc, SREQ, m_sreq, level, q.size(), audio_left, m_l, audio_right, m_r,
                 sample_tick, m_tick, overrun, m_ovr, underrun, m_unr);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    SLOAD_N = 1'b0; MDIN = w;
    @(negedge clk32);
    SLOAD_N = 1'b1;
    @(negedge clk32);
  endtask

  task automatic do_flush(input logic m16, input logic st);
    flush = 1'b1; mode_16 = m16; mode_stereo = st;
    @(negedge clk32);
    flush = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    @(negedge clk32);
    clr_status = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk32);
      n++;
    end while (!sample_tick && n < 3000);
    checks++;
    if (!sample_tick) begin
      failures++;
      $display("FAIL %s: no sample_tick within %0d cycles", name, n);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int t1;
    resb = 1'b0; enable = 1'b0; flush = 1'b0; mode_stereo = 1'b0; mode_16 = 1'b0;
    rate = 2'd3; MDIN = '0; SLOAD_N = 1'b1; clr_status = 1'b0;
    repeat (3) @(negedge clk32);
    check("reset SREQ", 32'(SREQ), 32'd0);
    check("reset level", 32'(level), 32'd0);
    check("reset left", 32'(audio_left), 32'd0);
    check("reset tick", 32'(sample_tick), 32'd0);
    resb = 1'b1;

    // fill: 16-bit mono, SREQ threshold at 2 free slots
    mode_16 = 1'b1; mode_stereo = 1'b0; enable = 1'b1;
    @(negedge clk32);
    check("fill SREQ empty", 32'(SREQ), 32'd1);
    push_word(16'h1111);
    push_word(16'h2222);
    check("fill SREQ lvl2", 32'(SREQ), 32'd1);
    push_word(16'h3333);
    check("fill SREQ lvl3", 32'(SREQ), 32'd0);
    check("fill level3", 32'(level), 32'd3);
    wait_tick("fill tick");
    check("fill pop left", 32'(audio_left), 32'h1111);
    check("fill pop level", 32'(level), 32'd2);
    check("fill pop SREQ", 32'(SREQ), 32'd1);

    // 8-bit mono: high byte then low byte, 640 clocks apart
    do_flush(1'b0, 1'b0);
    push_word(16'h7F80);
    wait_tick("m8 tick1");
    t1 = cyc;
    check("m8 t1 left", 32'(audio_left), 32'h7F00);
    check("m8 t1 right", 32'(audio_right), 32'h7F00);
    check("m8 t1 level", 32'(level), 32'd1);
    wait_tick("m8 tick2");
    check("m8 period", 32'(cyc - t1), 32'd640);
    check("m8 t2 left", 32'(audio_left), 32'h8000);
    check("m8 t2 right", 32'(audio_right), 32'h8000);
    check("m8 t2 level", 32'(level), 32'd0);

    // 8-bit stereo
    do_flush(1'b0, 1'b1);
    push_word(16'h7F80);
    wait_tick("s8 tick");
    check("s8 left", 32'(audio_left), 32'h7F00);
    check("s8 right", 32'(audio_right), 32'h8000);
    check("s8 level", 32'(level), 32'd0);

    // 16-bit stereo
    do_flush(1'b1, 1'b1);
    push_word(16'h1234);
    push_word(16'hABCD);
    check("s16 level2", 32'(level), 32'd2);
    wait_tick("s16 tick");
    check("s16 left", 32'(audio_left), 32'h1234);
    check("s16 right", 32'(audio_right), 32'hABCD);
    check("s16 level0", 32'(level), 32'd0);

    // underrun: empty FIFO at tick holds outputs
    pulse_clr();
    check("unr cleared pre", 32'(underrun), 32'd0);
    wait_tick("unr tick");
    check("unr flag", 32'(underrun), 32'd1);
    check("unr hold left", 32'(audio_left), 32'h1234);
    check("unr hold right", 32'(audio_right), 32'hABCD);
    pulse_clr();
    check("unr clr", 32'(underrun), 32'd0);

    // overrun vs simultaneous push/pop on a full FIFO
    do_flush(1'b1, 1'b0);
    wait_tick("ovr ref tick");
    for (int i = 1; i <= 4; i++) push_word(16'hA000 + 16'(i));
    check("ovr full level", 32'(level), 32'd4);
    check("ovr full SREQ", 32'(SREQ), 32'd0);
    pulse_clr();
    repeat (629) @(negedge clk32);
    SLOAD_N = 1'b0; MDIN = 16'hA005;
    @(negedge clk32);
    SLOAD_N = 1'b1;
    @(negedge clk32);
    check("sim tick", 32'(sample_tick), 32'd1);
    check("sim level", 32'(level), 32'd4);
    check("sim no ovr", 32'(overrun), 32'd0);
    check("sim left", 32'(audio_left), 32'hA001);
    push_word(16'hA006);
    check("ovr flag", 32'(overrun), 32'd1);
    check("ovr level", 32'(level), 32'd4);

    // asynchronous reset mid-playback
    #3;
    resb = 1'b0;
    #1;
    check("async SREQ", 32'(SREQ), 32'd0);
    check("async level", 32'(level), 32'd0);
    check("async left", 32'(audio_left), 32'd0);
    check("async right", 32'(audio_right), 32'd0);
    check("async tick", 32'(sample_tick), 32'd0);
    check("async ovr", 32'(overrun), 32'd0);
    @(negedge clk32);
    resb = 1'b1;
    repeat (2) @(negedge clk32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
